ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_pkg.sv | 18 +
 rtl/ram_p.sv | 23 ++
 rtl/ram_arbiter.sv | 116 +++++++++++
 tb/tb_ram_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and default widths for the two-requester RAM arbiter.
package ram_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

endpackage

// File: rtl/ram_p.sv
// Single-port RAM: synchronous write, registered read (read-before-write on the same edge).
module ram_p #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

    // Contents are deliberately not reset so they survive an arbiter reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= data_in;
        end
        data_out <= mem[addr];
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter giving two requesters shared access to one ram_p instance.
module ram_arbiter
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,

    input  logic                  req_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    output logic                  ack_a,
    output logic [DATA_WIDTH-1:0] rdata_a,
    output logic                  gnt_a,

    input  logic                  req_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  ack_b,
    output logic [DATA_WIDTH-1:0] rdata_b,
    output logic                  gnt_b
);

    state_t                state;
    grant_t                last_grant;
    grant_t                win;
    grant_t                lat_owner;
    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_dout;

    // On contention the requester that was not served last wins.
    always_comb begin
        win = GRANT_A;
        if (req_a && req_b) begin
            win = (last_grant == GRANT_A) ? GRANT_B : GRANT_A;
        end else if (req_b) begin
            win = GRANT_B;
        end
    end

    assign ram_we = (state == ST_ISSUE) && lat_we;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            last_grant <= GRANT_B;
            lat_owner  <= GRANT_A;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            ack_a      <= 1'b0;
            ack_b      <= 1'b0;
            gnt_a      <= 1'b0;
            gnt_b      <= 1'b0;
            rdata_a    <= '0;
            rdata_b    <= '0;
        end else begin
            ack_a <= 1'b0;
            ack_b <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_a || req_b) begin
                        state      <= ST_ISSUE;
                        last_grant <= win;
                        lat_owner  <= win;
                        lat_we     <= (win == GRANT_A) ? we_a    : we_b;
                        lat_addr   <= (win == GRANT_A) ? addr_a  : addr_b;
                        lat_wdata  <= (win == GRANT_A) ? wdata_a : wdata_b;
                        gnt_a      <= (win == GRANT_A);
                        gnt_b      <= (win == GRANT_B);
                    end
                end
                ST_ISSUE: begin
                    state <= ST_RESP;
                end
                // RAM read data for the latched address is valid here.
                ST_RESP: begin
                    state <= ST_IDLE;
                    gnt_a <= 1'b0;
                    gnt_b <= 1'b0;
                    ack_a <= (lat_owner == GRANT_A);
                    ack_b <= (lat_owner == GRANT_B);
                    if (!lat_we) begin
                        if (lat_owner == GRANT_A) begin
                            rdata_a <= ram_dout;
                        end else begin
                            rdata_b <= ram_dout;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    ram_p #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clock    (clock),
        .we       (ram_we),
        .addr     (lat_addr),
        .data_in  (lat_wdata),
        .data_out (ram_dout)
    );

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: expected acks are queued at drive time and checked on arrival.
module tb_ram_arbiter;
    import ram_pkg::*;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          req_a, we_a, req_b, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wdata_a, wdata_b;
    logic          ack_a, gnt_a, ack_b, gnt_b;
    logic [DW-1:0] rdata_a, rdata_b;

    typedef struct {
        logic          is_b;
        logic          is_read;
        logic [DW-1:0] rdata;
        int            exp_cyc;
    } sb_item_t;

    sb_item_t sb[$];
    int       cyc = 0;
    int       tests_run = 0;
    int       tests_failed = 0;

    ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .req_a   (req_a),
        .we_a    (we_a),
        .addr_a  (addr_a),
        .wdata_a (wdata_a),
        .ack_a   (ack_a),
        .rdata_a (rdata_a),
        .gnt_a   (gnt_a),
        .req_b   (req_b),
        .we_b    (we_b),
        .addr_b  (addr_b),
        .wdata_b (wdata_b),
        .ack_b   (ack_b),
        .rdata_b (rdata_b),
        .gnt_b   (gnt_b)
    );

    always #2 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock of monitoring: sample at the falling edge, retire acks, release served requests.
    task automatic step();
        sb_item_t it;
        @(negedge clock);
        if (gnt_a || gnt_b) check_eq("gnt_excl", 32'(gnt_a & gnt_b), 0);
        if (ack_a || ack_b) begin
            check_eq("ack_excl", 32'(ack_a & ack_b), 0);
            if (sb.size() == 0) begin
                check_eq("unexp_ack", {30'd0, ack_a, ack_b}, 0);
            end else begin
                it = sb.pop_front();
                check_eq("ack_owner", 32'(ack_b), 32'(it.is_b));
                check_eq("ack_cycle", cyc, it.exp_cyc);
                if (it.is_read)
                    check_eq(it.is_b ? "rdata_b" : "rdata_a",
                             32'(it.is_b ? rdata_b : rdata_a), 32'(it.rdata));
            end
            if (ack_a) req_a = 1'b0;
            if (ack_b) req_b = 1'b0;
        end
    endtask

    task automatic start_req(input logic is_b, input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd, input int lat);
        sb_item_t it;
        it.is_b    = is_b;
        it.is_read = !we;
        it.rdata   = exp_rd;
        it.exp_cyc = cyc + lat;
        sb.push_back(it);
        if (is_b) begin
            we_b = we; addr_b = addr; wdata_b = wdata; req_b = 1'b1;
        end else begin
            we_a = we; addr_a = addr; wdata_a = wdata; req_a = 1'b1;
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        if (sb.size() != 0) begin
            check_eq("timeout", sb.size(), 0);
            sb.delete();
            req_a = 1'b0;
            req_b = 1'b0;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        req_a = 0; we_a = 0; addr_a = '0; wdata_a = '0;
        req_b = 0; we_b = 0; addr_b = '0; wdata_b = '0;
        repeat (3) step();
        check_eq("rst_ack_a", 32'(ack_a), 0);
        check_eq("rst_ack_b", 32'(ack_b), 0);
        check_eq("rst_gnt_a", 32'(gnt_a), 0);
        check_eq("rst_gnt_b", 32'(gnt_b), 0);
        check_eq("rst_rdata_a", 32'(rdata_a), 0);
        check_eq("rst_rdata_b", 32'(rdata_b), 0);
        reset_n = 1'b1;
        step();

        // Write by A, read back by B; A's read register must stay untouched.
        start_req(1'b0, 1'b1, 8'h05, 16'h1234, 16'h0000, 3);
        wait_done(20);
        start_req(1'b1, 1'b0, 8'h05, 16'h0000, 16'h1234, 3);
        wait_done(20);
        check_eq("rdata_a_hold", 32'(rdata_a), 0);

        // Contention: A first (B served last), then B; a second pair goes to A again.
        start_req(1'b0, 1'b1, 8'h10, 16'h00AA, 16'h0000, 3);
        start_req(1'b1, 1'b1, 8'h11, 16'h00BB, 16'h0000, 6);
        wait_done(30);
        start_req(1'b0, 1'b0, 8'h10, 16'h0000, 16'h00AA, 3);
        start_req(1'b1, 1'b0, 8'h11, 16'h0000, 16'h00BB, 6);
        wait_done(30);
        check_eq("rdata_b_hold", 32'(rdata_b), 32'h00BB);

        // Requester withdraws and scrambles its inputs once the access is latched.
        start_req(1'b0, 1'b1, 8'hFF, 16'hBEEF, 16'h0000, 3);
        step();
        check_eq("gnt_a_issue", 32'(gnt_a), 1);
        req_a = 1'b0; we_a = 1'b0; addr_a = 8'h00; wdata_a = 16'h0BAD;
        wait_done(20);
        start_req(1'b1, 1'b0, 8'hFF, 16'h0000, 16'hBEEF, 3);
        wait_done(20);

        // Reset during ISSUE must abort the write with no ack.
        start_req(1'b0, 1'b1, 8'h00, 16'h1111, 16'h0000, 3);
        wait_done(20);
        we_a = 1'b1; addr_a = 8'h00; wdata_a = 16'h5555; req_a = 1'b1;
        step();
        check_eq("gnt_a_pre_rst", 32'(gnt_a), 1);
        reset_n = 1'b0;
        #1;
        check_eq("midrst_state", 32'(dut.state), 32'(ST_IDLE));
        check_eq("midrst_gnt_a", 32'(gnt_a), 0);
        check_eq("midrst_ack_a", 32'(ack_a), 0);
        check_eq("midrst_rdata_b", 32'(rdata_b), 0);
        req_a = 1'b0;
        step();
        reset_n = 1'b1;
        repeat (5) step();
        start_req(1'b1, 1'b0, 8'h00, 16'h0000, 16'h1111, 3);
        wait_done(20);

        // Boundary addresses with extreme data values.
        start_req(1'b0, 1'b1, 8'h00, 16'hFFFF, 16'h0000, 3);
        wait_done(20);
        start_req(1'b1, 1'b1, 8'hFF, 16'h0001, 16'h0000, 3);
        wait_done(20);
        start_req(1'b0, 1'b0, 8'hFF, 16'h0000, 16'h0001, 3);
        wait_done(20);
        start_req(1'b1, 1'b0, 8'h00, 16'h0000, 16'hFFFF, 3);
        wait_done(20);
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
